rob_alloc_ctrl: RTL and testbench

// - Pointer/occupancy controller for the 64-entry reorder buffer.
// - Sits between Dispatch, the execution units and the commit stage.
// - Hands Dispatch the next free tag (rob_free_entry) and a full flag (rob_is_full).
// - Tracks per-entry valid/done bits; presents the oldest completed entry for in-order retire.
// - Squashes all entries younger than a mispredicted branch on flush.

---
 rtl/rob_pkg.sv | 17 +
 rtl/rob_alloc_ctrl.sv | 100 ++++++++++
 tb/tb_rob_alloc_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: depth, tag type and age helper.
// Dispatch and the reservation stations import the same rob_tag_t.
package rob_pkg;

    localparam int unsigned ROB_DEPTH = 64;
    localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned ROB_CNT_W = ROB_IDX_W + 1;

    typedef logic [ROB_IDX_W-1:0] rob_tag_t;
    typedef logic [ROB_CNT_W-1:0] rob_cnt_t;

    // Age of a tag relative to head; modulo wrap falls out of the tag width.
    function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
        return rob_tag_t'(tag - head);
    endfunction

endpackage

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer pointer/occupancy controller: allocation, completion,
// in-order retire and squash of entries younger than a mispredicted branch.
module rob_alloc_ctrl
    import rob_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     alloc_req,
    output rob_tag_t rob_free_entry,
    output logic     rob_is_full,
    output logic     rob_is_empty,
    output rob_cnt_t rob_count,
    input  logic     complete_valid,
    input  rob_tag_t complete_tag,
    output logic     commit_valid,
    output rob_tag_t commit_tag,
    input  logic     commit_ready,
    input  logic     flush,
    input  rob_tag_t flush_tag
);

    localparam int unsigned DEPTH = ROB_DEPTH;

    rob_tag_t         head_q, head_d;
    rob_tag_t         tail_q, tail_d;
    rob_cnt_t         count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] squash;
    logic             alloc_fire;
    logic             commit_fire;
    rob_tag_t         flush_age;

    // Outputs decode registered state only.
    assign rob_free_entry = tail_q;
    assign rob_count      = count_q;
    assign rob_is_full    = (count_q == rob_cnt_t'(DEPTH));
    assign rob_is_empty   = (count_q == rob_cnt_t'(0));
    assign commit_valid   = valid_q[head_q] && done_q[head_q];
    assign commit_tag     = head_q;

    always_comb begin
        alloc_fire  = alloc_req && !rob_is_full && !flush;
        commit_fire = commit_valid && commit_ready;
        flush_age   = rob_age(flush_tag, head_q);
        squash      = '0;
        valid_d     = valid_q;
        done_d      = done_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q + rob_cnt_t'(alloc_fire) - rob_cnt_t'(commit_fire);

        for (int unsigned t = 0; t < DEPTH; t++) begin
            squash[t] = flush && valid_q[t]
                        && (rob_age(rob_tag_t'(t), head_q) > flush_age);
        end

        // A completion to an entry being squashed this cycle is dropped.
        if (complete_valid && valid_q[complete_tag] && !squash[complete_tag]) begin
            done_d[complete_tag] = 1'b1;
        end

        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + rob_tag_t'(1);
        end

        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + rob_tag_t'(1);
        end

        // Flush keeps the branch itself and everything older.
        if (flush) begin
            tail_d  = flush_tag + rob_tag_t'(1);
            valid_d = valid_d & ~squash;
            done_d  = done_d & ~squash;
            count_d = rob_cnt_t'(flush_age) + rob_cnt_t'(1) - rob_cnt_t'(commit_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl: vector table plus hand-written
// fill/wrap/simultaneous-event/reset sequences.
module tb_rob_alloc_ctrl;
    import rob_pkg::*;

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     alloc_req = 1'b0;
    rob_tag_t rob_free_entry;
    logic     rob_is_full;
    logic     rob_is_empty;
    rob_cnt_t rob_count;
    logic     complete_valid = 1'b0;
    rob_tag_t complete_tag = '0;
    logic     commit_valid;
    rob_tag_t commit_tag;
    logic     commit_ready = 1'b0;
    logic     flush = 1'b0;
    rob_tag_t flush_tag = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rob_alloc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .rob_free_entry (rob_free_entry),
        .rob_is_full    (rob_is_full),
        .rob_is_empty   (rob_is_empty),
        .rob_count      (rob_count),
        .complete_valid (complete_valid),
        .complete_tag   (complete_tag),
        .commit_valid   (commit_valid),
        .commit_tag     (commit_tag),
        .commit_ready   (commit_ready),
        .flush          (flush),
        .flush_tag      (flush_tag)
    );

    typedef struct {
        bit r;
        bit a;
        bit cv;
        int ct;
        bit cr;
        bit f;
        int ft;
        int e_free;
        int e_cnt;
        bit e_cv;
        int e_ctag;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit r, bit a, bit cv, int ct, bit cr, bit f, int ft,
                               int e_free, int e_cnt, bit e_cv, int e_ctag);
        vec_t x;
        x.r = r; x.a = a; x.cv = cv; x.ct = ct; x.cr = cr; x.f = f; x.ft = ft;
        x.e_free = e_free; x.e_cnt = e_cnt; x.e_cv = e_cv; x.e_ctag = e_ctag;
        return x;
    endfunction

    task automatic cmp(string nm, string field, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
        end
    endtask

    task automatic chk(string nm, int e_free, int e_cnt, bit e_cv, int e_ctag);
        cmp(nm, "rob_free_entry", int'(rob_free_entry), e_free);
        cmp(nm, "rob_count", int'(rob_count), e_cnt);
        cmp(nm, "rob_is_full", int'(rob_is_full), (e_cnt == 64) ? 1 : 0);
        cmp(nm, "rob_is_empty", int'(rob_is_empty), (e_cnt == 0) ? 1 : 0);
        cmp(nm, "commit_valid", int'(commit_valid), int'(e_cv));
        cmp(nm, "commit_tag", int'(commit_tag), e_ctag);
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic cyc(bit r, bit a, bit cv, int ct, bit cr, bit f, int ft);
        reset          = r;
        alloc_req      = a;
        complete_valid = cv;
        complete_tag   = rob_tag_t'(ct);
        commit_ready   = cr;
        flush          = f;
        flush_tag      = rob_tag_t'(ft);
        if (f && !r) begin
            assert (int'(rob_age(rob_tag_t'(ft), commit_tag)) < int'(rob_count))
            else $error("illegal flush of non-live tag %0d", ft);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; alloc_req = 1'b0; complete_valid = 1'b0;
        commit_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        // T2 out-of-order completion and in-order retire
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0, 1,1,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0, 2,2,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0, 3,3,0,0));
        tbl.push_back(v(0,1,0,0,0,0,0, 4,4,0,0));
        tbl.push_back(v(0,0,1,2,0,0,0, 4,4,0,0));
        tbl.push_back(v(0,0,1,1,0,0,0, 4,4,0,0));
        tbl.push_back(v(0,0,1,3,0,0,0, 4,4,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0, 4,4,1,0));
        tbl.push_back(v(0,0,0,0,1,0,0, 4,3,1,1));
        tbl.push_back(v(0,0,0,0,1,0,0, 4,2,1,2));
        tbl.push_back(v(0,0,0,0,1,0,0, 4,1,1,3));
        tbl.push_back(v(0,0,0,0,1,0,0, 4,0,0,4));
        // T3 flush squashes 5..9, late completion of 7 ignored
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0));
        for (int k = 1; k <= 10; k++) tbl.push_back(v(0,1,0,0,0,0,0, k,k,0,0));
        tbl.push_back(v(0,0,1,7,0,0,0, 10,10,0,0));
        tbl.push_back(v(0,0,0,0,0,1,4, 5,5,0,0));
        tbl.push_back(v(0,0,1,7,0,0,0, 5,5,0,0));
        for (int k = 0; k <= 4; k++) tbl.push_back(v(0,0,1,k,0,0,0, 5,5,1,0));
        tbl.push_back(v(0,0,0,0,1,0,0, 5,4,1,1));
        tbl.push_back(v(0,0,0,0,1,0,0, 5,3,1,2));
        tbl.push_back(v(0,0,0,0,1,0,0, 5,2,1,3));
        tbl.push_back(v(0,0,0,0,1,0,0, 5,1,1,4));
        tbl.push_back(v(0,0,0,0,1,0,0, 5,0,0,5));
        tbl.push_back(v(0,1,0,0,0,0,0, 6,1,0,5));
        tbl.push_back(v(0,1,0,0,0,0,0, 7,2,0,5));
        tbl.push_back(v(0,1,0,0,0,0,0, 8,3,0,5));
        tbl.push_back(v(0,0,1,5,0,0,0, 8,3,1,5));
        tbl.push_back(v(0,0,1,6,0,0,0, 8,3,1,5));
        tbl.push_back(v(0,0,0,0,1,0,0, 8,2,1,6));
        tbl.push_back(v(0,0,0,0,1,0,0, 8,1,0,7));

        // Reset state
        cyc(1,0,0,0,0,0,0);
        cyc(1,1,1,0,1,0,0);
        chk("reset", 0, 0, 0, 0);

        // T1 fill to full, drop 65th, complete head
        for (int i = 0; i < 64; i++) begin
            cyc(0,1,0,0,0,0,0);
            chk($sformatf("fill%0d", i), (i + 1) % 64, i + 1, 0, 0);
        end
        cyc(0,1,0,0,0,0,0);
        chk("alloc_when_full", 0, 64, 0, 0);
        cyc(0,0,1,0,0,0,0);
        chk("complete_head", 0, 64, 1, 0);

        // T5a commit + alloc while full: alloc dropped
        cyc(0,1,0,0,1,0,0);
        chk("full_commit_alloc", 0, 63, 0, 1);
        cyc(0,1,0,0,0,0,0);
        chk("refill_after_commit", 1, 64, 0, 1);

        // Table vectors
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].a, tbl[i].cv, tbl[i].ct, tbl[i].cr, tbl[i].f, tbl[i].ft);
            chk($sformatf("vec%0d", i), tbl[i].e_free, tbl[i].e_cnt, tbl[i].e_cv, tbl[i].e_ctag);
        end

        // T4 wrap: move head/tail to 60, allocate across the boundary, flush at 62
        cyc(1,0,0,0,0,0,0);
        for (int i = 0; i < 60; i++) cyc(0,1,0,0,0,0,0);
        for (int i = 0; i < 60; i++) cyc(0,0,1,i,0,0,0);
        for (int i = 0; i < 60; i++) cyc(0,0,0,0,1,0,0);
        chk("wrap_start", 60, 0, 0, 60);
        for (int i = 0; i < 8; i++) begin
            cyc(0,1,0,0,0,0,0);
            chk($sformatf("wrap_alloc%0d", i), (61 + i) % 64, i + 1, 0, 60);
        end
        cyc(0,0,1,1,0,1,62);
        chk("wrap_flush62", 63, 3, 0, 60);
        cyc(0,0,1,60,0,0,0);
        cyc(0,0,1,61,0,0,0);
        cyc(0,0,1,62,0,0,0);
        chk("wrap_completed", 63, 3, 1, 60);
        cyc(0,0,0,0,1,0,0);
        chk("wrap_commit60", 63, 2, 1, 61);
        cyc(0,0,0,0,1,0,0);
        cyc(0,0,0,0,1,0,0);
        chk("wrap_drained", 63, 0, 0, 63);

        // T5b flush at head while the head commits
        for (int i = 0; i < 3; i++) cyc(0,1,0,0,0,0,0);
        chk("pre_head_flush", 2, 3, 0, 63);
        cyc(0,0,1,63,0,0,0);
        chk("head63_done", 2, 3, 1, 63);
        cyc(0,1,0,0,1,1,63);
        chk("flush_head_commit", 0, 0, 0, 0);

        // T6 reset with 20 live entries and head ready to commit
        cyc(1,0,0,0,0,0,0);
        for (int i = 0; i < 20; i++) cyc(0,1,0,0,0,0,0);
        cyc(0,0,1,0,0,0,0);
        chk("pre_reset_live", 20, 20, 1, 0);
        cyc(1,1,0,0,1,0,0);
        chk("mid_reset", 0, 0, 0, 0);
        cyc(0,1,0,0,0,0,0);
        chk("post_reset_alloc", 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
